uart_rx_frame_ctrl: RTL and testbench

//  Sequencer between the UART receiver and the system side. Drives Rx_EN and
//  Rx_baud_select, assembles FRAME_BYTES consecutive error-free bytes into one

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_timeout_timer.sv | 31 +++
 rtl/uart_rx_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive frame controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [2:0] BAUD_DEFAULT       = 3'b111;
  localparam int         FRAME_BYTES_DEF    = 4;
  localparam int         TIMEOUT_CYCLES_DEF = 50000;
  localparam int         TMR_W_DEF          = 16;

  // Error counter never wraps; it sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte timeout counter. The expired output is high while enabled and
// the count has reached TIMEOUT_CYCLES-1.
module uart_timeout_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TMR_W          = TMR_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive sequencer: enables the receiver, packs FRAME_BYTES clean bytes
// into a frame and offers it on a valid/ready port. FRAME_CHECKSUM_EN adds a
// trailing XOR checksum byte that must match before the frame is released.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int FRAME_BYTES    = FRAME_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TMR_W          = TMR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               cfg_baud_select,
  input  logic                     startBitFound,
  input  logic [7:0]               Rx_DATA,
  input  logic                     Rx_FERROR,
  input  logic                     Rx_PERROR,
  input  logic                     Rx_VALID,
  output logic                     Rx_EN,
  output logic [2:0]               Rx_baud_select,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     err_frame,
  output logic [7:0]               err_count
);

  localparam int IDX_W = $clog2(FRAME_BYTES + 1);
`ifdef FRAME_CHECKSUM_EN
  localparam int LAST_IDX = FRAME_BYTES;
`else
  localparam int LAST_IDX = FRAME_BYTES - 1;
`endif

  state_e                   state_q, state_d;
  logic                     rx_en_q, rx_en_d;
  logic [2:0]               baud_q, baud_d;
  logic [8*FRAME_BYTES-1:0] frame_data_q, frame_data_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     err_frame_q, err_frame_d;
  logic [7:0]               err_count_q, err_count_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif

  logic tmr_clr, tmr_expired, abort, byte_ok;

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (state_q == RECV),
    .expired(tmr_expired)
  );

  assign byte_ok = Rx_VALID && !Rx_FERROR && !Rx_PERROR;

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    err_frame_d   = 1'b0;
    err_count_d   = err_count_q;
    byte_idx_d    = byte_idx_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    tmr_clr       = (state_q != RECV);
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d     = cfg_baud_select;
        byte_idx_d = '0;
        if (startBitFound) state_d = RECV;
      end
      RECV: begin
        if (byte_ok) begin
          tmr_clr = 1'b1;
          for (int i = 0; i < FRAME_BYTES; i++)
            if (byte_idx_q == IDX_W'(i))
              frame_data_d[8*(FRAME_BYTES-1-i) +: 8] = Rx_DATA;
`ifdef FRAME_CHECKSUM_EN
          csum_d = csum_q ^ Rx_DATA;
`endif
          if (byte_idx_q == IDX_W'(LAST_IDX)) begin
`ifdef FRAME_CHECKSUM_EN
            // Checksum byte lands outside the store loop; only compare it.
            if (Rx_DATA == csum_q) begin
              state_d       = HOLD;
              frame_valid_d = 1'b1;
              byte_idx_d    = '0;
            end else begin
              abort = 1'b1;
            end
`else
            state_d       = HOLD;
            frame_valid_d = 1'b1;
            byte_idx_d    = '0;
`endif
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else if (Rx_VALID) begin
          abort = 1'b1;
        end else if (tmr_expired) begin
          abort = 1'b1;
        end
      end
      HOLD: begin
        if (Rx_VALID) err_count_d = sat_inc8(err_count_q);
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err_frame_d = 1'b1;
      err_count_d = sat_inc8(err_count_q);
      byte_idx_d  = '0;
      tmr_clr     = 1'b1;
      state_d     = IDLE;
    end
`ifdef FRAME_CHECKSUM_EN
    if (state_d != RECV) csum_d = 8'h00;
`endif
    rx_en_d = (state_d == RECV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rx_en_q       <= 1'b0;
      baud_q        <= BAUD_DEFAULT;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_frame_q   <= 1'b0;
      err_count_q   <= 8'h00;
      byte_idx_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      rx_en_q       <= rx_en_d;
      baud_q        <= baud_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      err_frame_q   <= err_frame_d;
      err_count_q   <= err_count_d;
      byte_idx_q    <= byte_idx_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign Rx_EN          = rx_en_q;
  assign Rx_baud_select = baud_q;
  assign frame_data     = frame_data_q;
  assign frame_valid    = frame_valid_q;
  assign err_frame      = err_frame_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected frames are queued as they
// are sent and compared when the consumer handshake completes.
module tb_uart_rx_frame_ctrl;
  localparam int FB = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    cfg_baud_select = 3'b010;
  logic          startBitFound = 1'b0;
  logic [7:0]    Rx_DATA = 8'h00;
  logic          Rx_FERROR = 1'b0, Rx_PERROR = 1'b0, Rx_VALID = 1'b0;
  logic          Rx_EN;
  logic [2:0]    Rx_baud_select;
  logic [8*FB-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic          err_frame;
  logic [7:0]    err_count;

  int            n_checks = 0, n_pass = 0;
  logic [8*FB-1:0] exp_q[$];
  logic [8*FB-1:0] mon_exp;
  logic [7:0]    exp_err = 8'h00;

  uart_rx_frame_ctrl #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
    .clk(clk), .reset(reset), .cfg_baud_select(cfg_baud_select),
    .startBitFound(startBitFound), .Rx_DATA(Rx_DATA), .Rx_FERROR(Rx_FERROR),
    .Rx_PERROR(Rx_PERROR), .Rx_VALID(Rx_VALID), .Rx_EN(Rx_EN),
    .Rx_baud_select(Rx_baud_select), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .err_frame(err_frame), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Consumer side: a handshake seen before the edge pops the scoreboard.
  always @(negedge clk) begin
    if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL frame_unexpected got=%h", frame_data);
      else begin
        mon_exp = exp_q.pop_front();
        if (frame_data !== mon_exp) $display("FAIL frame_data got=%h exp=%h", frame_data, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe);
    Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe; Rx_VALID = 1'b1;
    tick();
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
  endtask

  task automatic start_frame();
    startBitFound = 1'b1; tick(); startBitFound = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input logic [8*FB-1:0] f);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < FB; i++) s ^= f[8*i +: 8];
    return s;
  endfunction

  task automatic send_frame(input logic [8*FB-1:0] f);
    for (int i = 0; i < FB; i++) send_byte(f[8*(FB-1-i) +: 8], 1'b0, 1'b0);
`ifdef FRAME_CHECKSUM_EN
    send_byte(xsum(f), 1'b0, 1'b0);
`endif
  endtask

  task automatic accept();
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_checks++; if (Rx_EN !== 1'b0) $display("FAIL rst_rx_en got=%b exp=0", Rx_EN); else n_pass++;
    n_checks++; if (Rx_baud_select !== 3'b111) $display("FAIL rst_baud got=%b exp=111", Rx_baud_select); else n_pass++;
    n_checks++; if (frame_valid !== 1'b0 || err_frame !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", frame_valid, err_frame); else n_pass++;
    n_checks++; if (err_count !== 8'h00 || frame_data !== '0) $display("FAIL rst_data got=%h/%h exp=0/0", err_count, frame_data); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    tick();
    n_checks++; if (Rx_baud_select !== 3'b010) $display("FAIL idle_baud got=%b exp=010", Rx_baud_select); else n_pass++;
    start_frame();
    n_checks++; if (Rx_EN !== 1'b1) $display("FAIL recv_rx_en got=%b exp=1", Rx_EN); else n_pass++;
    cfg_baud_select = 3'b001;
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0);
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL early_valid got=%b exp=0", frame_valid); else n_pass++;
    exp_q.push_back(32'h11223344);
    send_byte(8'h44, 0, 0);
`ifdef FRAME_CHECKSUM_EN
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL csum_early_valid got=%b exp=0", frame_valid); else n_pass++;
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0, 0);
`endif
    n_checks++; if (frame_valid !== 1'b1 || frame_data !== 32'h11223344) $display("FAIL frame1 got=%b/%h exp=1/11223344", frame_valid, frame_data); else n_pass++;
    n_checks++; if (Rx_EN !== 1'b0 || Rx_baud_select !== 3'b010) $display("FAIL hold_en_baud got=%b/%b exp=0/010", Rx_EN, Rx_baud_select); else n_pass++;
  endtask

  task automatic test_hold();
    bit stable = 1'b1;
    send_byte(8'h99, 0, 0);
    exp_err = 8'h01;
    n_checks++; if (err_count !== exp_err || err_frame !== 1'b0) $display("FAIL overrun got=%h/%b exp=%h/0", err_count, err_frame, exp_err); else n_pass++;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (frame_valid !== 1'b1 || frame_data !== 32'h11223344) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL hold_stable got=%b exp=1", stable); else n_pass++;
    frame_ready = 1'b1; tick();
    n_checks++; if (frame_valid !== 1'b0) $display("FAIL valid_drop got=%b exp=0", frame_valid); else n_pass++;
    tick(); tick();
    frame_ready = 1'b0;
    n_checks++; if (frame_valid !== 1'b0 || Rx_baud_select !== 3'b001) $display("FAIL idle_after got=%b/%b exp=0/001", frame_valid, Rx_baud_select); else n_pass++;
  endtask

  task automatic test_parity_abort();
    reset = 1'b1; tick(); reset = 1'b0; exp_err = 8'h00;
    start_frame();
    send_byte(8'h55, 0, 0);
    send_byte(8'h66, 0, 1);
    exp_err = 8'h01;
    n_checks++; if (err_frame !== 1'b1 || err_count !== exp_err || Rx_EN !== 1'b0) $display("FAIL perr got=%b/%h/%b exp=1/%h/0", err_frame, err_count, Rx_EN, exp_err); else n_pass++;
    tick();
    n_checks++; if (err_frame !== 1'b0) $display("FAIL perr_pulse got=%b exp=0", err_frame); else n_pass++;
    start_frame();
    exp_q.push_back(32'hAABBCCDD);
    send_frame(32'hAABBCCDD);
    n_checks++; if (frame_valid !== 1'b1 || frame_data !== 32'hAABBCCDD) $display("FAIL frame2 got=%b/%h exp=1/aabbccdd", frame_valid, frame_data); else n_pass++;
    accept();
  endtask

  task automatic test_timeout();
    start_frame();
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    repeat (TO - 1) tick();
    n_checks++; if (err_frame !== 1'b0 || Rx_EN !== 1'b1) $display("FAIL to_early got=%b/%b exp=0/1", err_frame, Rx_EN); else n_pass++;
    tick();
    exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
    n_checks++; if (err_frame !== 1'b1 || err_count !== exp_err || Rx_EN !== 1'b0) $display("FAIL to_fire got=%b/%h/%b exp=1/%h/0", err_frame, err_count, Rx_EN, exp_err); else n_pass++;
    tick();
    start_frame();
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    repeat (TO - 1) tick();
    send_byte(8'h05, 0, 0);
    n_checks++; if (err_frame !== 1'b0 || Rx_EN !== 1'b1 || err_count !== exp_err) $display("FAIL to_race got=%b/%b/%h exp=0/1/%h", err_frame, Rx_EN, err_count, exp_err); else n_pass++;
    exp_q.push_back(32'h03040506);
    send_byte(8'h06, 0, 0);
`ifdef FRAME_CHECKSUM_EN
    send_byte(8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06, 0, 0);
`endif
    n_checks++; if (frame_valid !== 1'b1 || frame_data !== 32'h03040506) $display("FAIL to_frame got=%b/%h exp=1/03040506", frame_valid, frame_data); else n_pass++;
    accept();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      start_frame();
      send_byte(8'hEE, 1, 0);
      exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
    end
    n_checks++; if (err_count !== 8'hFF || err_frame !== 1'b1) $display("FAIL sat got=%h/%b exp=ff/1", err_count, err_frame); else n_pass++;
    start_frame();
    send_byte(8'hEE, 1, 0);
    n_checks++; if (err_count !== exp_err) $display("FAIL sat_nowrap got=%h exp=%h", err_count, exp_err); else n_pass++;
    start_frame();
    send_byte(8'h77, 0, 0); send_byte(8'h88, 0, 0);
    reset = 1'b1; tick();
    n_checks++; if (Rx_EN !== 1'b0 || Rx_baud_select !== 3'b111 || frame_valid !== 1'b0 || err_frame !== 1'b0) $display("FAIL midrst_ctl got=%b/%b/%b/%b exp=0/111/0/0", Rx_EN, Rx_baud_select, frame_valid, err_frame); else n_pass++;
    n_checks++; if (err_count !== 8'h00 || frame_data !== '0) $display("FAIL midrst_data got=%h/%h exp=0/0", err_count, frame_data); else n_pass++;
    reset = 1'b0; exp_err = 8'h00;
    tick();
    start_frame();
    exp_q.push_back(32'h9ABCDEF0);
    send_frame(32'h9ABCDEF0);
    n_checks++; if (frame_valid !== 1'b1 || frame_data !== 32'h9ABCDEF0) $display("FAIL post_rst_frame got=%b/%h exp=1/9abcdef0", frame_valid, frame_data); else n_pass++;
    accept();
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    tick();
    start_frame();
    exp_q.push_back(32'h01020304);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    send_byte(xsum(32'h01020304), 0, 0);
    n_checks++; if (frame_valid !== 1'b1 || frame_data !== 32'h01020304) $display("FAIL csum_ok got=%b/%h exp=1/01020304", frame_valid, frame_data); else n_pass++;
    accept();
    start_frame();
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    send_byte(8'h05, 0, 0);
    exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
    n_checks++; if (err_frame !== 1'b1 || frame_valid !== 1'b0 || err_count !== exp_err) $display("FAIL csum_bad got=%b/%b/%h exp=1/0/%h", err_frame, frame_valid, err_count, exp_err); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_hold();
    test_parity_abort();
    test_timeout();
    test_saturate();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL frames_pending got=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
